// File: rtl/gsim_residual_check.sv
// Residual checker for the GSIM solver: r_i = (A*x)_i - b_i for the 16x16
// heptadiagonal stencil (-1, 6, -13, 20, -13, 6, -1), Q16.16.
//
// state  | meaning
// LOAD_B | capturing b[0..15] on in_en
// WAIT_X | shifting x[0..15] into the window on out_valid
// FLUSH  | three zero shifts to drain rows 13..15
// DONE   | results held; in_en starts the next frame
module gsim_residual_check #(
  parameter int N     = 16,
  parameter int RES_W = 40,
  parameter int TOL   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_en,
  input  logic [15:0]      b_in,
  input  logic             out_valid,
  input  logic [31:0]      x_out,
  output logic             res_valid,
  output logic [RES_W-1:0] res_out,
  output logic [3:0]       res_idx,
  output logic             done,
  output logic             pass,
  output logic [RES_W-1:0] max_abs
);

  typedef enum logic [1:0] {LOAD_B, WAIT_X, FLUSH, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] b_mem [N];
  // Only w1..w6 are stored: the oldest tap of the post-shift window is w1.
  logic [31:0] w [1:6];
  logic [3:0]  bidx, xidx;
  logic [1:0]  fcnt;

  logic        shift, emit, new_frame;
  logic [31:0] shift_in;
  logic [3:0]  row;
  logic [31:0] tap [7];
  logic signed [RES_W-1:0] t [7];
  logic signed [RES_W-1:0] bterm, res_nx;
  logic [RES_W-1:0]        abs_nx, max_nx;

  always_comb begin
    state_nx  = state;
    shift     = 1'b0;
    shift_in  = '0;
    emit      = 1'b0;
    row       = '0;
    new_frame = 1'b0;
    case (state)
      LOAD_B: if (in_en && bidx == 4'(N-1)) state_nx = WAIT_X;
      WAIT_X: if (out_valid) begin
        shift    = 1'b1;
        shift_in = x_out;
        emit     = (xidx >= 4'd3);
        row      = xidx - 4'd3;
        if (xidx == 4'(N-1)) state_nx = FLUSH;
      end
      FLUSH: begin
        shift = 1'b1;
        emit  = 1'b1;
        row   = 4'd13 + {2'b00, fcnt};
        if (fcnt == 2'd2) state_nx = DONE;
      end
      DONE: if (in_en) begin
        new_frame = 1'b1;
        state_nx  = LOAD_B;
      end
      default: state_nx = LOAD_B;
    endcase
  end

  // Residual is formed from the window as it will look after this shift,
  // so the row is registered on the same edge that centres it.
  always_comb begin
    tap[0] = w[1];
    for (int k = 1; k < 6; k++) tap[k] = w[k+1];
    tap[6] = shift_in;
    for (int k = 0; k < 7; k++) t[k] = RES_W'(signed'(tap[k]));
    bterm  = RES_W'(signed'(b_mem[row])) <<< 16;
    res_nx = - t[0]
             + ((t[1] <<< 2) + (t[1] <<< 1))
             - ((t[2] <<< 3) + (t[2] <<< 2) + t[2])
             + ((t[3] <<< 4) + (t[3] <<< 2))
             - ((t[4] <<< 3) + (t[4] <<< 2) + t[4])
             + ((t[5] <<< 2) + (t[5] <<< 1))
             - t[6]
             - bterm;
    abs_nx = res_nx[RES_W-1] ? RES_W'(-res_nx) : RES_W'(res_nx);
    max_nx = (abs_nx > max_abs) ? abs_nx : max_abs;
  end

  always_ff @(posedge clk) begin
    if (state == LOAD_B && in_en) b_mem[bidx] <= b_in;
    else if (new_frame)           b_mem[0]    <= b_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_B;
      bidx      <= '0;
      xidx      <= '0;
      fcnt      <= '0;
      for (int k = 1; k <= 6; k++) w[k] <= '0;
      res_valid <= 1'b0;
      res_out   <= '0;
      res_idx   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      max_abs   <= '0;
    end else begin
      state     <= state_nx;
      res_valid <= emit;
      if (emit) begin
        res_out <= res_nx;
        res_idx <= row;
        max_abs <= max_nx;
      end
      if (state == LOAD_B && in_en) bidx <= bidx + 4'd1;
      if (state == WAIT_X && out_valid) xidx <= xidx + 4'd1;
      if (shift) for (int k = 1; k <= 6; k++) w[k] <= tap[k];
      if (state == FLUSH) fcnt <= (fcnt == 2'd2) ? 2'd0 : fcnt + 2'd1;
      if (state == FLUSH && fcnt == 2'd2) begin
        done <= 1'b1;
        pass <= (max_nx <= RES_W'(TOL));
      end
      if (new_frame) begin
        bidx    <= 4'd1;
        xidx    <= '0;
        done    <= 1'b0;
        pass    <= 1'b0;
        max_abs <= '0;
        for (int k = 1; k <= 6; k++) w[k] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gsim_residual_check.sv
// Directed bench for gsim_residual_check: table of frames with hand-computed
// residuals, plus a mid-frame reset sequence.
module tb_gsim_residual_check;

  logic        clk = 1'b0;
  logic        reset, in_en, out_valid;
  logic [15:0] b_in;
  logic [31:0] x_out;
  logic        res_valid, done, pass;
  logic [39:0] res_out, max_abs;
  logic [3:0]  res_idx;

  gsim_residual_check dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .out_valid(out_valid), .x_out(x_out), .res_valid(res_valid),
    .res_out(res_out), .res_idx(res_idx), .done(done), .pass(pass),
    .max_abs(max_abs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] cap_r [64];
  logic [3:0]  cap_i [64];
  int          cap_c [64];
  int          cap_n = 0;
  always @(negedge clk) begin
    if (res_valid) begin
      cap_r[cap_n % 64] <= res_out;
      cap_i[cap_n % 64] <= res_idx;
      cap_c[cap_n % 64] <= cyc;
      cap_n <= cap_n + 1;
    end
  end

  typedef struct {
    logic [15:0][15:0] b;
    logic [15:0][31:0] x;
    logic [15:0][39:0] exp_r;
    logic [39:0]       exp_max;
    logic              exp_pass;
    int                gap;
    bit                early;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int v);
    int   start, t15, c;
    logic was_done;
    was_done = done;
    start    = cap_n;
    t15      = 0;
    for (int i = 0; i < 16; i++) begin
      in_en     = 1'b1;
      b_in      = vecs[v].b[i];
      out_valid = vecs[v].early && (i % 4 == 1);
      x_out     = 32'h7fff_0000;
      tick();
      if (i == 0 && was_done) chk($sformatf("v%0d done_drop", v), done, 0);
    end
    in_en = 1'b0; b_in = '0; out_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      out_valid = 1'b1;
      x_out     = vecs[v].x[i];
      tick();
      if (i == 15) t15 = cyc;
      out_valid = 1'b0;
      repeat (vecs[v].gap) tick();
    end
    c = 0;
    while (!done && c < 40) begin
      tick();
      c++;
    end
    @(negedge clk);
    #1;
    chk($sformatf("v%0d done", v), done, 1);
    chk($sformatf("v%0d pulses", v), 64'(cap_n - start), 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("v%0d idx[%0d]", v, k), cap_i[(start + k) % 64], 64'(k));
      chk($sformatf("v%0d res[%0d]", v, k), cap_r[(start + k) % 64], vecs[v].exp_r[k]);
    end
    chk($sformatf("v%0d last_lat", v), 64'(cap_c[(start + 15) % 64] - t15), 3);
    chk($sformatf("v%0d pass", v), pass, vecs[v].exp_pass);
    chk($sformatf("v%0d max_abs", v), max_abs, vecs[v].exp_max);
  endtask

  initial begin
    int n0;
    foreach (vecs[i]) begin
      vecs[i].b = '0; vecs[i].x = '0; vecs[i].exp_r = '0;
      vecs[i].exp_max = '0; vecs[i].exp_pass = 1'b1;
      vecs[i].gap = 0; vecs[i].early = 1'b0;
    end
    // 1: single x[0] = 1.0 against b = 0
    vecs[1].x[0] = 32'h0001_0000;
    vecs[1].exp_r[0] = 40'h14_0000;  vecs[1].exp_r[1] = -40'sd851968;
    vecs[1].exp_r[2] = 40'h06_0000;  vecs[1].exp_r[3] = -40'sd65536;
    vecs[1].exp_max = 40'h14_0000;   vecs[1].exp_pass = 1'b0;
    // 2: b matched to A*x -> zero residuals
    vecs[2].x[0] = 32'h0001_0000;
    vecs[2].b[0] = 16'h0014; vecs[2].b[1] = 16'hFFF3;
    vecs[2].b[2] = 16'h0006; vecs[2].b[3] = 16'hFFFF;
    // 3: same with gapped out_valid and early pulses during LOAD_B
    vecs[3] = vecs[2]; vecs[3].gap = 2; vecs[3].early = 1'b1;
    // 4/5: x[15] in LSBs, exercises flush zeros and the tolerance
    vecs[4].x[15] = 32'd3;
    vecs[4].exp_r[12] = -40'sd3;  vecs[4].exp_r[13] = 40'd18;
    vecs[4].exp_r[14] = -40'sd39; vecs[4].exp_r[15] = 40'd60;
    vecs[4].exp_max = 40'd60;
    vecs[5].x[15] = 32'd4;
    vecs[5].exp_r[12] = -40'sd4;  vecs[5].exp_r[13] = 40'd24;
    vecs[5].exp_r[14] = -40'sd52; vecs[5].exp_r[15] = 40'd80;
    vecs[5].exp_max = 40'd80; vecs[5].exp_pass = 1'b0;
    // 6: b only, checks b row alignment and sign
    vecs[6].b[7] = 16'h0001; vecs[6].b[8] = 16'hFFFF;
    vecs[6].exp_r[7] = -40'sd65536; vecs[6].exp_r[8] = 40'h1_0000;
    vecs[6].exp_max = 40'h1_0000; vecs[6].exp_pass = 1'b0;
    // 7: interior x[8] = -1.0
    vecs[7].x[8] = 32'hFFFF_0000;
    vecs[7].exp_r[5]  = 40'h1_0000;    vecs[7].exp_r[6]  = -40'sd393216;
    vecs[7].exp_r[7]  = 40'hD_0000;    vecs[7].exp_r[8]  = -40'sd1310720;
    vecs[7].exp_r[9]  = 40'hD_0000;    vecs[7].exp_r[10] = -40'sd393216;
    vecs[7].exp_r[11] = 40'h1_0000;
    vecs[7].exp_max = 40'h14_0000; vecs[7].exp_pass = 1'b0;

    reset = 1'b1; in_en = 1'b0; out_valid = 1'b0; b_in = '0; x_out = '0;
    repeat (2) tick();
    chk("rst res_valid", res_valid, 0);
    chk("rst outputs", {done, pass, res_idx, res_out, max_abs}, 0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) run_frame(v);

    // Mid-frame reset after x[7]
    for (int i = 0; i < 16; i++) begin
      in_en = 1'b1; b_in = '0; tick();
    end
    in_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_valid = 1'b1; x_out = (i == 0) ? 32'h0001_0000 : 32'h0000_0000; tick();
    end
    out_valid = 1'b0;
    reset = 1'b1; tick();
    chk("midrst res_valid", res_valid, 0);
    chk("midrst outputs", {done, pass, res_idx, res_out, max_abs}, 0);
    n0 = cap_n;
    reset = 1'b0;
    repeat (10) tick();
    chk("midrst no pulses", 64'(cap_n - n0), 0);
    run_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
